// File: rtl/bin2bcd_seq_conv.sv
// rtl/bin2bcd_seq_conv.sv - sequential shift-add-3 binary to packed BCD converter
//
// Converts one binaryNumberWidth-bit word per load into numberOfDigits BCD
// digits, one input bit per clock, with an optional two's-complement front end.
//
// Ports:
//   clk               rising-edge clock
//   rst               asynchronous active-low reset
//   binaryNumber      value to convert, sampled only when a load is accepted
//   load              start request, accepted in IDLE or DONE
//   busy              high while the W shift cycles run; load ignored then
//   BinaryDecimal     packed BCD result, digit 0 = units, all 9s on overflow
//   to2_10Sum         one-cycle done pulse; results valid from the same edge
//   overflow          value did not fit in numberOfDigits digits
//   isNegative        input was negative (signedMode only)
//   significantDigits digits up to the most significant nonzero (1 for zero)

module bin2bcd_seq_conv #(
  parameter int binaryNumberWidth = 32,
  parameter int busWidth          = 4,
  parameter int numberOfDigits    = 10,
  parameter bit signedMode        = 1'b0
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [binaryNumberWidth-1:0]                 binaryNumber,
  input  logic                                         load,
  output logic                                         busy,
  output logic [numberOfDigits-1:0][busWidth-1:0]      BinaryDecimal,
  output logic                                         to2_10Sum,
  output logic                                         overflow,
  output logic                                         isNegative,
  output logic [$clog2(numberOfDigits+1)-1:0]          significantDigits
);

  localparam int W  = binaryNumberWidth;
  localparam int D  = numberOfDigits;
  localparam int AW = D * busWidth;
  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam int SW = $clog2(D + 1);

  generate
    if (busWidth != 4) begin : g_bad_bus_width
      $error("bin2bcd_seq_conv: busWidth must be 4");
    end
    if (W < 2) begin : g_bad_width
      $error("bin2bcd_seq_conv: binaryNumberWidth must be at least 2");
    end
    if (D < 1) begin : g_bad_digits
      $error("bin2bcd_seq_conv: numberOfDigits must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sticky_q, sticky_d;
  logic            neg_cap_q, neg_cap_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [AW-1:0]   bcd_q, bcd_d;
  logic            ovf_q, ovf_d;
  logic            neg_q, neg_d;
  logic [SW-1:0]   sig_q, sig_d;

  // Datapath for one double-dabble step and for input capture.
  logic [AW-1:0]   acc_adj;
  logic [AW-1:0]   acc_shift;
  logic [W-1:0]    sr_shift;
  logic            top_out;
  logic            neg_in;
  logic [W-1:0]    mag_in;

  function automatic logic [AW-1:0] all_nines();
    logic [AW-1:0] v;
    v = '0;
    for (int i = 0; i < D; i++) begin
      v[i*busWidth +: busWidth] = busWidth'(9);
    end
    return v;
  endfunction

  // Position of the highest nonzero digit, plus one; zero still reports one digit.
  function automatic logic [SW-1:0] count_sig(input logic [AW-1:0] a);
    logic [SW-1:0] n;
    n = SW'(1);
    for (int i = 0; i < D; i++) begin
      if (a[i*busWidth +: busWidth] != '0) begin
        n = SW'(i + 1);
      end
    end
    return n;
  endfunction

  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < D; i++) begin
      if (acc_q[i*busWidth +: busWidth] >= busWidth'(5)) begin
        acc_adj[i*busWidth +: busWidth] = acc_q[i*busWidth +: busWidth] + busWidth'(3);
      end
    end
    // A set top bit after adjustment means the top digit would reach 10 or more.
    top_out   = acc_adj[AW-1];
    acc_shift = {acc_adj[AW-2:0], shift_q[W-1]};
    sr_shift  = {shift_q[W-2:0], 1'b0};
  end

  always_comb begin
    neg_in = signedMode && binaryNumber[W-1];
    // Negating the most negative value wraps back to 2^(W-1), which is the
    // correct magnitude when read as unsigned.
    mag_in = neg_in ? (~binaryNumber + W'(1)) : binaryNumber;
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sticky_d  = sticky_q;
    neg_cap_d = neg_cap_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    neg_d     = neg_q;
    sig_d     = sig_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (load) begin
          state_d   = ST_SHIFT;
          shift_d   = mag_in;
          acc_d     = '0;
          cnt_d     = '0;
          sticky_d  = 1'b0;
          neg_cap_d = neg_in;
          busy_d    = 1'b1;
        end
      end

      ST_SHIFT: begin
        shift_d  = sr_shift;
        acc_d    = acc_shift;
        sticky_d = sticky_q | top_out;
        if (cnt_q == CW'(W - 1)) begin
          // Last shift: publish results straight from the post-shift value so
          // they line up with the done pulse.
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          ovf_d   = sticky_q | top_out;
          neg_d   = neg_cap_q;
          if (sticky_q | top_out) begin
            bcd_d = all_nines();
            sig_d = SW'(D);
          end else begin
            bcd_d = acc_shift;
            sig_d = count_sig(acc_shift);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      sticky_q  <= 1'b0;
      neg_cap_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      neg_q     <= 1'b0;
      sig_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sticky_q  <= sticky_d;
      neg_cap_q <= neg_cap_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      neg_q     <= neg_d;
      sig_q     <= sig_d;
    end
  end

  assign busy              = busy_q;
  assign BinaryDecimal     = bcd_q;
  assign to2_10Sum         = done_q;
  assign overflow          = ovf_q;
  assign isNegative        = neg_q;
  assign significantDigits = sig_q;

endmodule

// File: tb/tb_bin2bcd_seq_conv.sv
// tb/tb_bin2bcd_seq_conv.sv - scoreboard bench for bin2bcd_seq_conv
module tb_bin2bcd_seq_conv;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b0;

  // a: W=32 D=3, b: W=32 D=10, c: W=8 D=3 signed
  logic        ld_a, ld_b, ld_c;
  logic [31:0] bn_a, bn_b;
  logic [7:0]  bn_c;
  logic        busy_a, busy_b, busy_c;
  logic [2:0][3:0] bcd_a;
  logic [9:0][3:0] bcd_b;
  logic [2:0][3:0] bcd_c;
  logic        done_a, done_b, done_c;
  logic        ovf_a, ovf_b, ovf_c;
  logic        neg_a, neg_b, neg_c;
  logic [1:0]  sig_a;
  logic [3:0]  sig_b;
  logic [1:0]  sig_c;

  bin2bcd_seq_conv #(.binaryNumberWidth(32), .busWidth(4), .numberOfDigits(3), .signedMode(1'b0)) u_a (
    .clk(clk), .rst(rst), .binaryNumber(bn_a), .load(ld_a), .busy(busy_a), .BinaryDecimal(bcd_a),
    .to2_10Sum(done_a), .overflow(ovf_a), .isNegative(neg_a), .significantDigits(sig_a));

  bin2bcd_seq_conv #(.binaryNumberWidth(32), .busWidth(4), .numberOfDigits(10), .signedMode(1'b0)) u_b (
    .clk(clk), .rst(rst), .binaryNumber(bn_b), .load(ld_b), .busy(busy_b), .BinaryDecimal(bcd_b),
    .to2_10Sum(done_b), .overflow(ovf_b), .isNegative(neg_b), .significantDigits(sig_b));

  bin2bcd_seq_conv #(.binaryNumberWidth(8), .busWidth(4), .numberOfDigits(3), .signedMode(1'b1)) u_c (
    .clk(clk), .rst(rst), .binaryNumber(bn_c), .load(ld_c), .busy(busy_c), .BinaryDecimal(bcd_c),
    .to2_10Sum(done_c), .overflow(ovf_c), .isNegative(neg_c), .significantDigits(sig_c));

  typedef struct {
    logic [63:0] bcd;
    logic        ovf;
    logic        neg;
    int          sig;
    int          cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic [63:0] bcd, input logic ovf,
                     input logic neg, input int sig);
    check({tag, "_bcd"}, bcd, e.bcd);
    check({tag, "_overflow"}, 64'(ovf), 64'(e.ovf));
    check({tag, "_isNegative"}, 64'(neg), 64'(e.neg));
    check({tag, "_sigdigits"}, 64'(sig), 64'(e.sig));
    check({tag, "_done_cycle"}, 64'(cyc), 64'(e.cyc));
  endtask

  task automatic unexpected(input string tag);
    total++;
    bad++;
    $display("FAIL %s_unexpected_done: got done pulse expected none pending", tag);
  endtask

  always @(negedge clk) begin
    if (done_a === 1'b1) begin
      if (q_a.size() == 0) unexpected("a");
      else cmp("a", q_a.pop_front(), {52'b0, bcd_a}, ovf_a, neg_a, int'(sig_a));
    end
  end

  always @(negedge clk) begin
    if (done_b === 1'b1) begin
      if (q_b.size() == 0) unexpected("b");
      else cmp("b", q_b.pop_front(), {24'b0, bcd_b}, ovf_b, neg_b, int'(sig_b));
    end
  end

  always @(negedge clk) begin
    if (done_c === 1'b1) begin
      if (q_c.size() == 0) unexpected("c");
      else cmp("c", q_c.pop_front(), {52'b0, bcd_c}, ovf_c, neg_c, int'(sig_c));
    end
  end

  // Called at a negedge just before the load is driven; done is due W edges after the accepting edge.
  task automatic push(input int inst, input logic [63:0] bcd, input logic ovf, input logic neg, input int sig);
    exp_t e;
    e.bcd = bcd;
    e.ovf = ovf;
    e.neg = neg;
    e.sig = sig;
    e.cyc = cyc + 1 + ((inst == 2) ? 8 : 32);
    case (inst)
      0: q_a.push_back(e);
      1: q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  task automatic load_a(input logic [31:0] v);
    ld_a = 1'b1; bn_a = v;
    @(negedge clk);
    ld_a = 1'b0;
  endtask

  task automatic load_b(input logic [31:0] v);
    ld_b = 1'b1; bn_b = v;
    @(negedge clk);
    ld_b = 1'b0;
  endtask

  task automatic load_c(input logic [7:0] v);
    ld_c = 1'b1; bn_c = v;
    @(negedge clk);
    ld_c = 1'b0;
  endtask

  function automatic logic done_of(input int inst);
    case (inst)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  task automatic wait_done(input int inst, input string name);
    int n;
    n = 0;
    while (done_of(inst) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (done_of(inst) !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done in %0d cycles expected done", name, n);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    ld_a = 1'b0; ld_b = 1'b0; ld_c = 1'b0;
    bn_a = '0; bn_b = '0; bn_c = '0;

    #12;
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_bcd", {52'b0, bcd_a}, 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_overflow", 64'(ovf_a), 64'd0);
    check("rst_isNegative", 64'(neg_a), 64'd0);
    check("rst_sigdigits", 64'(sig_a), 64'd0);
    #8 rst = 1'b1;
    @(negedge clk);

    // 11 on a 3-digit converter, with busy length and pulse width
    push(0, 64'h011, 1'b0, 1'b0, 2);
    load_a(32'h0000_000B);
    n = 0;
    while (busy_a === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("a_busy_cycles", 64'(n), 64'd32);
    check("a_done_after_busy", 64'(done_a), 64'd1);
    @(negedge clk);
    check("a_done_one_cycle", 64'(done_a), 64'd0);

    // full-scale 32-bit into 10 digits
    push(1, 64'h42_9496_7295, 1'b0, 1'b0, 10);
    load_b(32'hFFFF_FFFF);
    wait_done(1, "b_max");
    @(negedge clk);

    // overflow saturation, then the largest value that fits
    push(0, 64'h999, 1'b1, 1'b0, 3);
    load_a(32'd1000);
    wait_done(0, "a_1000");
    @(negedge clk);
    push(0, 64'h999, 1'b0, 1'b0, 3);
    load_a(32'd999);
    wait_done(0, "a_999");
    @(negedge clk);

    // signed 8-bit: -11, most negative, zero
    push(2, 64'h011, 1'b0, 1'b1, 2);
    load_c(8'hF5);
    wait_done(2, "c_f5");
    @(negedge clk);
    push(2, 64'h128, 1'b0, 1'b1, 3);
    load_c(8'h80);
    wait_done(2, "c_80");
    @(negedge clk);
    push(2, 64'h000, 1'b0, 1'b0, 1);
    load_c(8'h00);
    wait_done(2, "c_00");
    @(negedge clk);

    // load while busy is ignored; load on the done cycle is accepted
    push(0, 64'h042, 1'b0, 1'b0, 2);
    load_a(32'd42);
    repeat (3) @(negedge clk);
    check("a_hold_bcd_busy", {52'b0, bcd_a}, 64'h999);
    check("a_hold_ovf_busy", 64'(ovf_a), 64'd0);
    check("a_hold_sig_busy", 64'(sig_a), 64'd3);
    load_a(32'd7);
    wait_done(0, "a_42");
    push(0, 64'h007, 1'b0, 1'b0, 1);
    load_a(32'd7);
    wait_done(0, "a_7");
    @(negedge clk);

    // reset mid-conversion
    load_a(32'd500);
    repeat (8) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_busy", 64'(busy_a), 64'd0);
    check("midrst_bcd", {52'b0, bcd_a}, 64'd0);
    check("midrst_done", 64'(done_a), 64'd0);
    check("midrst_overflow", 64'(ovf_a), 64'd0);
    check("midrst_sigdigits", 64'(sig_a), 64'd0);
    check("midrst_b_bcd", {24'b0, bcd_b}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (45) @(negedge clk);
    check("postrst_busy", 64'(busy_a), 64'd0);
    push(0, 64'h305, 1'b0, 1'b0, 3);
    load_a(32'd305);
    wait_done(0, "a_305");
    @(negedge clk);

    repeat (3) @(negedge clk);
    check("a_queue_empty", 64'(q_a.size()), 64'd0);
    check("b_queue_empty", 64'(q_b.size()), 64'd0);
    check("c_queue_empty", 64'(q_c.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
